fetch_ctrl: RTL and testbench

//  Sequencer for the instruction-fetch datapath. Owns the PC, issues one instruction-memory

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_wait_timer.sv | 29 ++
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  // Counter width that can hold 0..max without collapsing to zero bits.
  function automatic int cnt_width(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating un-acked-cycle counter; o_expired fires on the cycle the count reaches MAX_WAIT.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CNT_W = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;

  assign w_next    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign o_expired = (MAX_WAIT != 0) && i_count && (w_next >= LIM);

  always_ff @(posedge clk) begin
    if (rst)          r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_count) r_cnt <= w_next;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs one req/ack read at a time, hands words to Decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid;
  logic              r_fetch_err;

  logic              w_busy;
  logic              w_clear;
  logic              w_count;
  logic              w_expired;
  logic [ADDR_W-1:0] w_idle_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_busy    = (r_state == WAIT) || (r_state == DRAIN);
  assign w_idle_pc = redirect_valid ? redirect_pc : r_pc;
  assign w_pc_inc  = r_pc + ADDR_W'(PC_STEP);

  // Timer restarts on every transition into WAIT or DRAIN.
  assign w_clear = (r_state == IDLE)
                || ((r_state == HOLD) && (redirect_valid || !stall))
                || ((r_state == WAIT) && !mem_ack && redirect_valid);
  assign w_count = w_busy && !mem_ack;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_count   (w_count),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_mem_addr   <= '0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pc       <= w_idle_pc;
          r_mem_addr <= w_idle_pc;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (mem_ack) begin
            if (redirect_valid) begin
              r_pc    <= redirect_pc;
              r_state <= IDLE;
            end else begin
              r_inst       <= mem_rdata;
              r_inst_pc    <= r_mem_addr;
              r_inst_valid <= 1'b1;
              r_pc         <= w_pc_inc;
              r_state      <= HOLD;
            end
          end else if (w_expired) begin
            r_fetch_err <= 1'b1;
            r_state     <= ERR;
          end else if (redirect_valid) begin
            // Request stays outstanding; its word is thrown away in DRAIN.
            r_pc    <= redirect_pc;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_valid) r_pc <= redirect_pc;
          if (mem_ack) begin
            r_state <= IDLE;
          end else if (w_expired) begin
            r_fetch_err <= 1'b1;
            r_state     <= ERR;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_inst_valid <= 1'b0;
            r_pc         <= redirect_pc;
            r_mem_addr   <= redirect_pc;
            r_state      <= WAIT;
          end else if (!stall) begin
            r_inst_valid <= 1'b0;
            r_mem_addr   <= r_pc;
            r_state      <= WAIT;
          end
        end
        ERR: begin
          r_inst_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req    = w_busy;
  assign mem_addr   = r_mem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign pc         = r_pc;
  assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl plus hand sequences for timeout and PC wrap.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        mem_req,    mem_req2;
  logic [31:0] mem_addr,   mem_addr2;
  logic        inst_valid, inst_valid2;
  logic [31:0] inst,       inst2;
  logic [31:0] inst_pc,    inst_pc2;
  logic [31:0] pc,         pc2;
  logic        fetch_err,  fetch_err2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc(pc), .fetch_err(fetch_err)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .pc(pc2), .fetch_err(fetch_err2)
  );

  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc, e_pc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic rv, logic [31:0] rpc, logic a,
                              logic [31:0] rd, logic req, logic [31:0] addr, logic iv,
                              logic [31:0] in, logic [31:0] ipc, logic [31:0] p, logic er);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.ack = a; v.rdata = rd;
    v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_inst = in; v.e_ipc = ipc;
    v.e_pc = p; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic a, input logic [31:0] rd);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc; mem_ack = a; mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //            rst s rv rpc     ack rdata       req addr    iv inst        ipc     pc      err
    vecs.push_back(mk(1,0,0,32'h0,  1,32'h0,       0,32'h0,   0,32'h0,    32'h0,  32'h0,  0));
    vecs.push_back(mk(1,0,0,32'h0,  0,32'h0,       0,32'h0,   0,32'h0,    32'h0,  32'h0,  0));
    vecs.push_back(mk(1,0,0,32'h0,  1,32'h55,      0,32'h0,   0,32'h0,    32'h0,  32'h0,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h0,   0,32'h0,    32'h0,  32'h0,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h0,   0,32'h0,    32'h0,  32'h0,  0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hA0,      0,32'h0,   1,32'hA0,   32'h0,  32'h4,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h4,   0,32'hA0,   32'h0,  32'h4,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h4,   0,32'hA0,   32'h0,  32'h4,  0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hA1,      0,32'h4,   1,32'hA1,   32'h4,  32'h8,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h8,   0,32'hA1,   32'h4,  32'h8,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h8,   0,32'hA1,   32'h4,  32'h8,  0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hA2,      0,32'h8,   1,32'hA2,   32'h8,  32'hC,  0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,       0,32'h8,   1,32'hA2,   32'h8,  32'hC,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'hC,   0,32'hA2,   32'h8,  32'hC,  0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'hC,   0,32'hA2,   32'h8,  32'hC,  0));
    vecs.push_back(mk(0,0,1,32'h100,0,32'h0,       1,32'hC,   0,32'hA2,   32'h8,  32'h100,0));
    vecs.push_back(mk(0,0,1,32'h200,0,32'h0,       1,32'hC,   0,32'hA2,   32'h8,  32'h200,0));
    vecs.push_back(mk(0,0,1,32'h100,0,32'h0,       1,32'hC,   0,32'hA2,   32'h8,  32'h100,0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hDEAD,    0,32'hC,   0,32'hA2,   32'h8,  32'h100,0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,       1,32'h100, 0,32'hA2,   32'h8,  32'h100,0));
    vecs.push_back(mk(0,0,1,32'h180,1,32'hBAD,     0,32'h100, 0,32'hA2,   32'h8,  32'h180,0));
    vecs.push_back(mk(0,0,1,32'h100,0,32'h0,       1,32'h100, 0,32'hA2,   32'h8,  32'h100,0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hB0,      0,32'h100, 1,32'hB0,   32'h100,32'h104,0));
    vecs.push_back(mk(0,0,1,32'h300,0,32'h0,       1,32'h300, 0,32'hB0,   32'h100,32'h300,0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hB1,      0,32'h300, 1,32'hB1,   32'h300,32'h304,0));
    vecs.push_back(mk(0,1,1,32'h100,0,32'h0,       1,32'h100, 0,32'hB1,   32'h300,32'h100,0));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hB2,      0,32'h100, 1,32'hB2,   32'h100,32'h104,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      step();
      chk($sformatf("v%0d mem_req", i),    32'(mem_req),    32'(vecs[i].e_req));
      chk($sformatf("v%0d mem_addr", i),   mem_addr,        vecs[i].e_addr);
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d inst", i),       inst,            vecs[i].e_inst);
      chk($sformatf("v%0d inst_pc", i),    inst_pc,         vecs[i].e_ipc);
      chk($sformatf("v%0d pc", i),         pc,              vecs[i].e_pc);
      chk($sformatf("v%0d fetch_err", i),  32'(fetch_err),  32'(vecs[i].e_err));
    end

    // Timeout: accept B2, then the request at 0x104 never gets an answer.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk("to_enter mem_req", 32'(mem_req), 32'd1);
    chk("to_enter mem_addr", mem_addr, 32'h104);
    for (int i = 1; i < 15; i++) begin
      step();
      chk($sformatf("to_wait%0d fetch_err", i), 32'(fetch_err), 32'd0);
      chk($sformatf("to_wait%0d mem_req", i),   32'(mem_req),   32'd1);
    end
    step();
    chk("to_hit fetch_err", 32'(fetch_err), 32'd1);
    chk("to_hit mem_req", 32'(mem_req), 32'd0);
    chk("to_hit inst_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'hEE);
      step();
      chk($sformatf("err_sticky%0d fetch_err", i), 32'(fetch_err), 32'd1);
      chk($sformatf("err_sticky%0d mem_req", i),   32'(mem_req),   32'd0);
      chk($sformatf("err_sticky%0d pc", i),        pc,             32'h104);
      chk($sformatf("err_sticky%0d inst_valid", i), 32'(inst_valid), 32'd0);
    end

    // Reset clears the error; the wrap instance starts at 0xFFFFFFFC.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    chk("err_rst fetch_err", 32'(fetch_err), 32'd0);
    chk("err_rst pc", pc, 32'h0);
    chk("wrap_rst pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_rst mem_addr", mem_addr2, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk("wrap_req1 mem_req", 32'(mem_req2), 32'd1);
    chk("wrap_req1 mem_addr", mem_addr2, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0);
    step();
    chk("wrap_ack inst_valid", 32'(inst_valid2), 32'd1);
    chk("wrap_ack inst_pc", inst_pc2, 32'hFFFF_FFFC);
    chk("wrap_ack pc", pc2, 32'h0);
    chk("wrap_ack inst", inst2, 32'hC0);
    chk("base_ack pc", pc, 32'h4);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk("wrap_req2 mem_req", 32'(mem_req2), 32'd1);
    chk("wrap_req2 mem_addr", mem_addr2, 32'h0);
    chk("base_req2 mem_addr", mem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
